// File: rtl/riscv_core_pc_pkg.sv
// riscv_core_pc_pkg
// Shared definitions for the fetch-stage PC generator and its return-address
// stack: the next-PC source encoding, the default reset PC and the RISC-V
// link-register indices used by the call/return predecoder.
package riscv_core_pc_pkg;

  // Source that produced the next fetch PC, highest priority first.
  typedef enum logic [2:0] {
    RECOVER = 3'd0,
    HOLD    = 3'd1,
    RAS     = 3'd2,
    BP      = 3'd3,
    SEQ     = 3'd4
  } pc_src_e;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // x1 (ra) and x5 (t0) are the architectural link registers.
  localparam logic [4:0] LINK_REG_X1 = 5'd1;
  localparam logic [4:0] LINK_REG_X5 = 5'd5;

  // True when a register index names one of the link registers.
  function automatic logic is_link_reg(input logic [4:0] idx);
    return (idx == LINK_REG_X1) || (idx == LINK_REG_X5);
  endfunction

endpackage

// File: rtl/riscv_core_ras.sv
// riscv_core_ras
// Speculative circular return-address stack. The pointer addresses the next
// free slot; the occupancy count saturates at RAS_DEPTH so that deep call
// chains overwrite the oldest entry instead of stalling. A restore reloads
// pointer and count from a pipeline checkpoint but leaves the entries alone.
// Ports:
//   clk, rst_n   clock and asynchronous active-low reset
//   push         write push_data at ptr and advance
//   pop          retreat ptr (ignored while empty)
//   push_data    return address to record
//   restore      load restore_ptr / restore_cnt (overrides push/pop)
//   top          entry at ptr-1
//   ptr, cnt     current pointer and occupancy
//   empty        cnt == 0
module riscv_core_ras
  import riscv_core_pc_pkg::*;
#(
  parameter int RAS_DEPTH = 8,
  parameter int ADDRLEN   = 32,
  localparam int PTRW     = $clog2(RAS_DEPTH),
  localparam int CNTW     = $clog2(RAS_DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               push,
  input  logic               pop,
  input  logic [ADDRLEN-1:0] push_data,
  input  logic               restore,
  input  logic [PTRW-1:0]    restore_ptr,
  input  logic [CNTW-1:0]    restore_cnt,
  output logic [ADDRLEN-1:0] top,
  output logic [PTRW-1:0]    ptr,
  output logic [CNTW-1:0]    cnt,
  output logic               empty
);

  logic [ADDRLEN-1:0] entries [RAS_DEPTH];
  logic [PTRW-1:0]    ptr_q;
  logic [CNTW-1:0]    cnt_q;
  logic [PTRW-1:0]    top_idx;

  // Depth is a power of two, so pointer arithmetic wraps for free.
  assign top_idx = ptr_q - PTRW'(1);
  assign top     = entries[top_idx];
  assign ptr     = ptr_q;
  assign cnt     = cnt_q;
  assign empty   = (cnt_q == '0);

  // A simultaneous push and pop (call that is also a return) replaces the
  // top entry in place; with an empty stack it degenerates to a plain push.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
      cnt_q <= '0;
      for (int i = 0; i < RAS_DEPTH; i++) begin
        entries[i] <= '0;
      end
    end else if (restore) begin
      ptr_q <= restore_ptr;
      cnt_q <= restore_cnt;
    end else if (push && pop && !empty) begin
      entries[top_idx] <= push_data;
    end else if (push) begin
      entries[ptr_q] <= push_data;
      ptr_q          <= ptr_q + PTRW'(1);
      if (cnt_q != CNTW'(RAS_DEPTH)) begin
        cnt_q <= cnt_q + CNTW'(1);
      end
    end else if (pop && !empty) begin
      ptr_q <= top_idx;
      cnt_q <= cnt_q - CNTW'(1);
    end
  end

endmodule

// File: rtl/riscv_core_fetch_pc_gen.sv
// riscv_core_fetch_pc_gen
// Fetch-stage PC generator. Holds the fetch PC and picks the next one from
// EX recovery, the return-address stack, the BTB/BHT prediction or the
// sequential increment (+2 compressed, +4 otherwise). Bit 0 of the next PC
// is always cleared.
// Ports:
//   i_clk, i_rst_n                 clock, asynchronous active-low reset
//   i_stall                        hold PC and RAS
//   i_misprediction                EX redirect (beats stall)
//   i_recovered_addr/_ras_ptr/_cnt redirect target and RAS checkpoint
//   i_bp_valid/_taken/_predicted_addr  BTB/BHT prediction for o_pc
//   i_is_compressed/_call/_ret     predecode of the instruction at o_pc
//   o_pc, o_next_pc, o_pc_src      current PC, next PC and its source
//   o_ras_ptr, o_ras_cnt           RAS checkpoint travelling with o_pc
module riscv_core_fetch_pc_gen
  import riscv_core_pc_pkg::*;
#(
  parameter int                 ADDRLEN   = 32,
  parameter logic [ADDRLEN-1:0] RESET_PC  = ADDRLEN'(DEFAULT_RESET_PC),
  parameter int                 RAS_DEPTH = 8,
  localparam int                PTRW      = $clog2(RAS_DEPTH),
  localparam int                CNTW      = $clog2(RAS_DEPTH + 1)
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_stall,
  input  logic               i_misprediction,
  input  logic [ADDRLEN-1:0] i_recovered_addr,
  input  logic [PTRW-1:0]    i_recovered_ras_ptr,
  input  logic [CNTW-1:0]    i_recovered_ras_cnt,
  input  logic               i_bp_valid,
  input  logic               i_bp_taken,
  input  logic [ADDRLEN-1:0] i_bp_predicted_addr,
  input  logic               i_is_compressed,
  input  logic               i_is_call,
  input  logic               i_is_ret,
  output logic [ADDRLEN-1:0] o_pc,
  output logic [ADDRLEN-1:0] o_next_pc,
  output pc_src_e            o_pc_src,
  output logic [PTRW-1:0]    o_ras_ptr,
  output logic [CNTW-1:0]    o_ras_cnt
);

  logic [ADDRLEN-1:0] pc;
  logic [ADDRLEN-1:0] seq_pc;
  logic [ADDRLEN-1:0] next_raw;
  logic [ADDRLEN-1:0] ras_top;
  logic               ras_empty;
  logic               push;
  logic               pop;

  assign seq_pc = pc + (i_is_compressed ? ADDRLEN'(2) : ADDRLEN'(4));

  // Stack only moves when the fetch actually advances and is not squashed.
  assign push = i_is_call & ~i_stall & ~i_misprediction;
  assign pop  = i_is_ret  & ~i_stall & ~i_misprediction;

  riscv_core_ras #(
    .RAS_DEPTH (RAS_DEPTH),
    .ADDRLEN   (ADDRLEN)
  ) u_ras (
    .clk         (i_clk),
    .rst_n       (i_rst_n),
    .push        (push),
    .pop         (pop),
    .push_data   (seq_pc),
    .restore     (i_misprediction),
    .restore_ptr (i_recovered_ras_ptr),
    .restore_cnt (i_recovered_ras_cnt),
    .top         (ras_top),
    .ptr         (o_ras_ptr),
    .cnt         (o_ras_cnt),
    .empty       (ras_empty)
  );

  // A return against an empty stack has no usable target, so it falls
  // through to the BTB or sequential path.
  always_comb begin
    next_raw = seq_pc;
    o_pc_src = SEQ;
    if (i_misprediction) begin
      next_raw = i_recovered_addr;
      o_pc_src = RECOVER;
    end else if (i_stall) begin
      next_raw = pc;
      o_pc_src = HOLD;
    end else if (i_is_ret && !ras_empty) begin
      next_raw = ras_top;
      o_pc_src = RAS;
    end else if (i_bp_valid && i_bp_taken) begin
      next_raw = i_bp_predicted_addr;
      o_pc_src = BP;
    end
  end

  assign o_next_pc = next_raw & ~ADDRLEN'(1);
  assign o_pc      = pc;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pc <= RESET_PC;
    end else begin
      pc <= o_next_pc;
    end
  end

endmodule
